// File: rtl/credit_pkg.sv
// Shared definitions for the credit-flow link (receiver and sender).
//   credit_state_e : credit-return state machine encoding
//   credit_ptr_inc : ring-pointer increment that wraps at an arbitrary depth
package credit_pkg;

    typedef enum logic {
        CREDIT_INIT,
        CREDIT_RUN
    } credit_state_e;

    // Wrap by explicit compare so non-power-of-two depths work.
    function automatic int unsigned credit_ptr_inc(input int unsigned ptr,
                                                   input int unsigned depth);
        return (ptr == depth - 32'd1) ? 32'd0 : ptr + 32'd1;
    endfunction

endpackage

// File: rtl/credit_receiver_if.sv
// Bundle of the credit-link write side and the valid/ready read side.
//   master : sender/consumer view (drives w_valid, w_data, r_ready)
//   slave  : credit_receiver view (drives w_credit, r_valid, r_data, level)
// With CREDIT_RECEIVER_OVERFLOW_CHECK_EN defined, the sticky overflow flag is added.
interface credit_receiver_if #(
    parameter int unsigned DATA_WIDTH = 1,
    parameter type         TYPE       = logic [DATA_WIDTH-1:0],
    parameter int unsigned DEPTH      = 4
);
    localparam int unsigned LVL_W = $clog2(DEPTH + 1);

    logic             w_valid;
    TYPE              w_data;
    logic             w_credit;
    logic             r_valid;
    logic             r_ready;
    TYPE              r_data;
    logic [LVL_W-1:0] level;
`ifdef CREDIT_RECEIVER_OVERFLOW_CHECK_EN
    logic             overflow;

    modport master (output w_valid, w_data, r_ready,
                    input  w_credit, r_valid, r_data, level, overflow);
    modport slave  (input  w_valid, w_data, r_ready,
                    output w_credit, r_valid, r_data, level, overflow);
`else
    modport master (output w_valid, w_data, r_ready,
                    input  w_credit, r_valid, r_data, level);
    modport slave  (input  w_valid, w_data, r_ready,
                    output w_credit, r_valid, r_data, level);
`endif

endinterface

// File: rtl/credit_fifo_mem.sv
// DEPTH-entry storage: synchronous write port, asynchronous read port.
//   clk            : write clock
//   we/waddr/wdata : write enable, address, payload
//   raddr/rdata    : combinational read
// Holds no reset; contents are undefined until written.
module credit_fifo_mem #(
    parameter type         TYPE   = logic,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 2
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  TYPE               wdata,
    input  logic [ADDR_W-1:0] raddr,
    output TYPE               rdata
);

    TYPE mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/credit_receiver.sv
// Receive end of a credit-flow link: buffers pushed items in a DEPTH-entry
// FIFO and presents them as a valid/ready stream; every pop is returned to
// the sender as a one-cycle w_credit pulse. With INIT_CREDITS=1 the receiver
// grants DEPTH credits after reset.
//   clk, rstn : clock, asynchronous active-low reset
//   bus       : credit_receiver_if.slave (w_valid, w_data, w_credit,
//               r_valid, r_ready, r_data, level [, overflow])
// Optional macro CREDIT_RECEIVER_OVERFLOW_CHECK_EN adds a sticky overflow
// flag and a simulation assertion on pushes into a full buffer.
module credit_receiver
    import credit_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 1,
    parameter type         TYPE         = logic [DATA_WIDTH-1:0],
    parameter int unsigned DEPTH        = 4,
    parameter bit          INIT_CREDITS = 1'b1
) (
    input logic              clk,
    input logic              rstn,
    credit_receiver_if.slave bus
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned LVL_W = $clog2(DEPTH + 1);
    localparam logic [LVL_W-1:0] FULL     = LVL_W'(DEPTH);
    localparam logic [PTR_W-1:0] INIT_END = PTR_W'(DEPTH - 1);
    localparam credit_state_e    RST_STATE = INIT_CREDITS ? CREDIT_INIT : CREDIT_RUN;

    logic [PTR_W-1:0] rd_ptr, wr_ptr;
    logic [LVL_W-1:0] count, count_nxt;
    logic             r_valid_q;
    logic             push, pop;
    TYPE              rdata;

    credit_state_e    state, state_nxt;
    logic [PTR_W-1:0] init_cnt, init_cnt_nxt;
    logic             w_credit_q, w_credit_nxt;

    // Pushes into a full buffer are dropped; pops only from registered valid.
    assign push      = bus.w_valid && (count != FULL);
    assign pop       = r_valid_q && bus.r_ready;
    assign count_nxt = count + LVL_W'(push) - LVL_W'(pop);

    // Pointers, occupancy and registered valid.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            r_valid_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= PTR_W'(credit_ptr_inc(32'(wr_ptr), DEPTH));
            end
            if (pop) begin
                rd_ptr <= PTR_W'(credit_ptr_inc(32'(rd_ptr), DEPTH));
            end
            count     <= count_nxt;
            r_valid_q <= (count_nxt != '0);
        end
    end

    credit_fifo_mem #(
        .TYPE   (TYPE),
        .DEPTH  (DEPTH),
        .ADDR_W (PTR_W)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (bus.w_data),
        .raddr (rd_ptr),
        .rdata (rdata)
    );

    // Credit-return state register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= RST_STATE;
            init_cnt   <= '0;
            w_credit_q <= 1'b0;
        end else begin
            state      <= state_nxt;
            init_cnt   <= init_cnt_nxt;
            w_credit_q <= w_credit_nxt;
        end
    end

    // INIT streams DEPTH back-to-back grants; RUN echoes each pop one cycle later.
    always_comb begin
        state_nxt    = state;
        init_cnt_nxt = init_cnt;
        w_credit_nxt = pop;
        case (state)
            CREDIT_INIT: begin
                w_credit_nxt = 1'b1;
                init_cnt_nxt = init_cnt + PTR_W'(1);
                if (init_cnt == INIT_END) begin
                    state_nxt = CREDIT_RUN;
                end
            end
            default: begin
            end
        endcase
    end

    assign bus.w_credit = w_credit_q;
    assign bus.r_valid  = r_valid_q;
    assign bus.r_data   = rdata;
    assign bus.level    = count;

`ifdef CREDIT_RECEIVER_OVERFLOW_CHECK_EN
    logic ovf_attempt;
    logic overflow_q;

    assign ovf_attempt = bus.w_valid && (count == FULL);

    // Sticky until reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            overflow_q <= 1'b0;
        end else if (ovf_attempt) begin
            overflow_q <= 1'b1;
        end
    end

    assign bus.overflow = overflow_q;

    always @(posedge clk) begin
        if (rstn) begin
            assert (!ovf_attempt)
                else $warning("credit_receiver: push while full, data dropped");
        end
    end
`endif

endmodule

// File: tb/tb_credit_receiver.sv
// Directed bench for credit_receiver: three instances (DEPTH=4/INIT=1,
// DEPTH=3/INIT=0, DEPTH=2/INIT=1) driven one at a time, with a per-instance
// queue holding expected read data and a small occupancy model.
module tb_credit_receiver;
    import credit_pkg::*;

    logic clk;
    logic rstn;

    logic       wv [3];
    logic [7:0] wd [3];
    logic       rr [3];
    logic       wc [3];
    logic       rv [3];
    logic [7:0] rd [3];
    logic [7:0] lv [3];
    logic       ov [3];

    int unsigned dep  [3] = '{4, 3, 2};
    int unsigned mlvl [3] = '{0, 0, 0};
    logic [7:0] q0 [$];
    logic [7:0] q1 [$];
    logic [7:0] q2 [$];

    int n_cmp = 0;
    int n_bad = 0;

    credit_receiver_if #(.DATA_WIDTH(8), .DEPTH(4)) if4 ();
    credit_receiver_if #(.DATA_WIDTH(8), .DEPTH(3)) if3 ();
    credit_receiver_if #(.DATA_WIDTH(8), .DEPTH(2)) if2 ();

    credit_receiver #(.DATA_WIDTH(8), .DEPTH(4), .INIT_CREDITS(1'b1))
        dut4 (.clk(clk), .rstn(rstn), .bus(if4));
    credit_receiver #(.DATA_WIDTH(8), .DEPTH(3), .INIT_CREDITS(1'b0))
        dut3 (.clk(clk), .rstn(rstn), .bus(if3));
    credit_receiver #(.DATA_WIDTH(8), .DEPTH(2), .INIT_CREDITS(1'b1))
        dut2 (.clk(clk), .rstn(rstn), .bus(if2));

    assign if4.w_valid = wv[0];
    assign if4.w_data  = wd[0];
    assign if4.r_ready = rr[0];
    assign if3.w_valid = wv[1];
    assign if3.w_data  = wd[1];
    assign if3.r_ready = rr[1];
    assign if2.w_valid = wv[2];
    assign if2.w_data  = wd[2];
    assign if2.r_ready = rr[2];

    assign wc[0] = if4.w_credit;
    assign wc[1] = if3.w_credit;
    assign wc[2] = if2.w_credit;
    assign rv[0] = if4.r_valid;
    assign rv[1] = if3.r_valid;
    assign rv[2] = if2.r_valid;
    assign rd[0] = if4.r_data;
    assign rd[1] = if3.r_data;
    assign rd[2] = if2.r_data;
    assign lv[0] = 8'(if4.level);
    assign lv[1] = 8'(if3.level);
    assign lv[2] = 8'(if2.level);
`ifdef CREDIT_RECEIVER_OVERFLOW_CHECK_EN
    assign ov[0] = if4.overflow;
    assign ov[1] = if3.overflow;
    assign ov[2] = if2.overflow;
`else
    assign ov[0] = 1'b0;
    assign ov[1] = 1'b0;
    assign ov[2] = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input int k, input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
            else begin
                n_bad++;
                $error("FAIL dut%0d %s: observed %0h expected %0h", k, tag, obs, exp);
            end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic qpush(input int k, input logic [7:0] d);
        case (k)
            0:       q0.push_back(d);
            1:       q1.push_back(d);
            default: q2.push_back(d);
        endcase
    endtask

    task automatic qpop(input int k, output logic [7:0] d);
        d = 8'hxx;
        case (k)
            0:       if (q0.size() > 0) d = q0.pop_front();
            1:       if (q1.size() > 0) d = q1.pop_front();
            default: if (q2.size() > 0) d = q2.pop_front();
        endcase
    endtask

    // One cycle on instance k (others idle): check head, apply, check credit/level.
    task automatic step(input int k, input logic v, input logic [7:0] d, input logic rdy);
        logic       exp_pop;
        logic       exp_push;
        logic [7:0] exp_d;
        for (int j = 0; j < 3; j++) begin
            wv[j] = 1'b0;
            wd[j] = 8'h00;
            rr[j] = 1'b0;
        end
        wv[k] = v;
        wd[k] = d;
        rr[k] = rdy;
        exp_pop = (mlvl[k] != 0) && rdy;
        chk(k, "r_valid", 32'(rv[k]), 32'(mlvl[k] != 0));
        if (exp_pop) begin
            qpop(k, exp_d);
            chk(k, "r_data", 32'(rd[k]), 32'(exp_d));
        end
        exp_push = v && (mlvl[k] < dep[k]);
        if (exp_push) qpush(k, d);
        mlvl[k] = mlvl[k] + 32'(exp_push) - 32'(exp_pop);
        tick();
        chk(k, "w_credit", 32'(wc[k]), 32'(exp_pop));
        chk(k, "level", 32'(lv[k]), mlvl[k]);
    endtask

    initial begin
        rstn = 1'b0;
        for (int j = 0; j < 3; j++) begin
            wv[j] = 1'b0;
            wd[j] = 8'h00;
            rr[j] = 1'b0;
        end

        // Reset values.
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            chk(k, "rst_r_valid", 32'(rv[k]), 32'd0);
            chk(k, "rst_level", 32'(lv[k]), 32'd0);
            chk(k, "rst_w_credit", 32'(wc[k]), 32'd0);
            chk(k, "rst_overflow", 32'(ov[k]), 32'd0);
        end

        // Initial credit grants: DEPTH pulses for INIT_CREDITS=1, none otherwise.
        rstn = 1'b1;
        for (int t = 1; t <= 6; t++) begin
            tick();
            chk(0, "init_credit", 32'(wc[0]), 32'(t <= 4));
            chk(1, "init_credit", 32'(wc[1]), 32'd0);
            chk(2, "init_credit", 32'(wc[2]), 32'(t <= 2));
            chk(0, "init_r_valid", 32'(rv[0]), 32'd0);
        end

        // Fill DEPTH=4 with no consumer; head stays 0xA.
        step(0, 1'b1, 8'h0A, 1'b0);
        chk(0, "head", 32'(rd[0]), 32'h0A);
        step(0, 1'b1, 8'h0B, 1'b0);
        chk(0, "head", 32'(rd[0]), 32'h0A);
        step(0, 1'b1, 8'h0C, 1'b0);
        chk(0, "head", 32'(rd[0]), 32'h0A);
        step(0, 1'b1, 8'h0D, 1'b0);
        chk(0, "head", 32'(rd[0]), 32'h0A);

        // Drain: A,B,C,D with one credit per pop, one cycle later.
        repeat (4) step(0, 1'b0, 8'h00, 1'b1);
        step(0, 1'b0, 8'h00, 1'b0);

        // Push into empty with ready: no fall-through, item appears next cycle.
        step(0, 1'b1, 8'h5E, 1'b1);
        step(0, 1'b0, 8'h00, 1'b1);
        step(0, 1'b0, 8'h00, 1'b0);

        // DEPTH=3 streaming through pointer wrap.
        for (int i = 0; i < 20; i++) begin
            step(1, 1'b1, 8'(i + 16), 1'b1);
        end
        step(1, 1'b0, 8'h00, 1'b1);
        step(1, 1'b0, 8'h00, 1'b0);

        // DEPTH=2 overflow: third push dropped.
        step(2, 1'b1, 8'h21, 1'b0);
        step(2, 1'b1, 8'h22, 1'b0);
        step(2, 1'b1, 8'h23, 1'b0);
`ifdef CREDIT_RECEIVER_OVERFLOW_CHECK_EN
        chk(2, "overflow", 32'(ov[2]), 32'd1);
`endif
        step(2, 1'b0, 8'h00, 1'b0);
`ifdef CREDIT_RECEIVER_OVERFLOW_CHECK_EN
        chk(2, "overflow_sticky", 32'(ov[2]), 32'd1);
`endif
        repeat (3) step(2, 1'b0, 8'h00, 1'b1);

        // Mid-stream reset: outputs clear immediately.
        step(0, 1'b1, 8'h77, 1'b0);
        step(0, 1'b1, 8'h78, 1'b0);
        rstn = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk(k, "midrst_r_valid", 32'(rv[k]), 32'd0);
            chk(k, "midrst_level", 32'(lv[k]), 32'd0);
            chk(k, "midrst_w_credit", 32'(wc[k]), 32'd0);
            chk(k, "midrst_overflow", 32'(ov[k]), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
